// File: rtl/r2r_adc_controller.sv
// R2R-ladder ADC controller: drives a registered DAC code into an R2R
// ladder and reads an external comparator, resolving the input either by a
// linear ramp search or by successive approximation (SAR).
module r2r_adc_controller #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             continuous,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [WIDTH-1:0] CODE_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MASK_MSB    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state;
  logic             comp_meta;
  logic             comp_s;
  logic             mode_q;        // 1 = SAR, 0 = ramp; frozen for the conversion
  logic [WIDTH-1:0] ramp_cnt;
  logic [WIDTH-1:0] sar_res;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] settle_cnt;

  logic [WIDTH-1:0] trial_code;
  logic             smp_done;
  logic [WIDTH-1:0] smp_result;
  logic [WIDTH-1:0] sar_next;
  logic [WIDTH-1:0] ramp_next;

  assign busy       = (state != S_IDLE);
  assign trial_code = mode_q ? (sar_res | mask) : ramp_cnt;

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_in;
      comp_s    <= comp_meta;
    end
  end

  // Decision taken in SAMPLE: next trial registers, completion and result
  always_comb begin
    smp_done   = 1'b0;
    sar_next   = sar_res;
    ramp_next  = ramp_cnt;
    smp_result = sar_res;
    if (mode_q) begin
      if (comp_s) sar_next = sar_res | mask;
      smp_done   = mask[0];
      smp_result = sar_next;
    end else if (!comp_s) begin
      // Comparator flipped: the input lies just below the current code
      smp_done   = 1'b1;
      smp_result = (ramp_cnt == '0) ? '0 : ramp_cnt - 1'b1;
    end else if (ramp_cnt == CODE_MAX) begin
      // Top of scale reached without a flip: saturate, never wrap
      smp_done   = 1'b1;
      smp_result = CODE_MAX;
    end else begin
      ramp_next  = ramp_cnt + 1'b1;
    end
  end

  // Conversion FSM with DAC code, result and settle-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      ramp_cnt   <= '0;
      sar_res    <= '0;
      mask       <= '0;
      settle_cnt <= '0;
      dac_code   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SET;
            mode_q   <= mode;
            ramp_cnt <= '0;
            sar_res  <= '0;
            mask     <= MASK_MSB;
          end
        end
        S_SET: begin
          dac_code   <= trial_code;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= S_SAMPLE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        S_SAMPLE: begin
          sar_res  <= sar_next;
          ramp_cnt <= ramp_next;
          mask     <= mask >> 1;
          if (smp_done) begin
            // Result and pulse are set here so they appear during DONE
            data       <= smp_result;
            data_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_SET;
          end
        end
        S_DONE: begin
          if (continuous) begin
            state    <= S_SET;
            mode_q   <= mode;
            ramp_cnt <= '0;
            sar_res  <= '0;
            mask     <= MASK_MSB;
          end else begin
            state    <= S_IDLE;
            dac_code <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r2r_adc_controller.sv
// Self-checking bench for r2r_adc_controller: a comparator model closes the
// loop around the DAC code, a reference model predicts result and completion
// cycle, and a monitor pops expectations whenever data_valid is seen.
module tb_r2r_adc_controller;

  localparam int W  = 8;
  localparam int SC = 4;
  localparam int STEP = SC + 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic         mode;
  logic         continuous;
  logic         comp_in;
  logic [W-1:0] dac_code;
  logic         busy;
  logic [W-1:0] data;
  logic         data_valid;

  logic [W-1:0] vin;
  int           comp_sel;   // 0 = ideal comparator on vin, 1 = tied 0, 2 = tied 1
  logic         glitch;
  logic         cmp_raw;

  typedef struct {
    int     data;
    longint due;
    bit     last;
  } exp_t;

  exp_t   sb[$];
  int     trace[$];
  bit     trace_en;
  longint cyc;
  int     n_checks;
  int     n_fail;

  r2r_adc_controller #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .continuous (continuous),
    .comp_in    (comp_in),
    .dac_code   (dac_code),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (comp_sel)
      1:       cmp_raw = 1'b0;
      2:       cmp_raw = 1'b1;
      default: cmp_raw = (vin >= dac_code);
    endcase
    comp_in = cmp_raw ^ glitch;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit cmp_f(input int c, input int v, input int sel);
    if (sel == 1) return 1'b0;
    if (sel == 2) return 1'b1;
    return (v >= c);
  endfunction

  // Behavioural reference: SAR finds the largest code the comparator accepts;
  // ramp walks codes upward until the first rejected code K.
  function automatic void ref_model(input bit m, input int v, input int sel,
                                    output int res, output int lat);
    if (m) begin
      res = 0;
      for (int c = 1; c < (1 << W); c++) if (cmp_f(c, v, sel)) res = c;
      lat = W * STEP + 1;
    end else begin
      int  k;
      bit  found;
      k = (1 << W) - 1;
      found = 0;
      for (int c = 0; c < (1 << W) && !found; c++)
        if (!cmp_f(c, v, sel)) begin k = c; found = 1; end
      if (!found)      res = (1 << W) - 1;
      else if (k == 0) res = 0;
      else             res = k - 1;
      lat = (k + 1) * STEP + 1;
    end
  endfunction

  // Monitor: compares each data_valid pulse against the oldest expectation
  initial begin
    bit chk_idle = 0;
    bit chk_busy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        chk_idle = 0;
        check("busy_after_done", busy, 0);
        check("dac_zero_idle", dac_code, 0);
      end else if (chk_busy) begin
        chk_busy = 0;
        check("busy_continuous", busy, 1);
      end
      if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", data, e.data);
          check("valid_cycle", cyc, e.due);
          if (e.last) chk_idle = 1;
          else        chk_busy = 1;
        end
      end
    end
  end

  // Records every change of the DAC code while tracing is enabled
  initial begin
    logic [W-1:0] prev = '0;
    forever begin
      @(negedge clk);
      if (trace_en && dac_code != prev) trace.push_back(int'(dac_code));
      prev = dac_code;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
  endtask

  task automatic issue(input bit m, input int v, input int sel, input bit last);
    int res, lat;
    vin = v[W-1:0];
    comp_sel = sel;
    mode = m;
    start = 1'b1;
    ref_model(m, v, sel, res, lat);
    sb.push_back('{res, cyc + lat, last});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_conv(input bit m, input int v, input int sel);
    @(negedge clk);
    continuous = 1'b0;
    issue(m, v, sel, 1'b1);
    mode = 1'($urandom);
    wait_drain(2000);
  endtask

  initial begin
    int sar_exp[8] = '{128, 64, 96, 112, 104, 100, 102, 101};
    int ramp_exp[4] = '{1, 2, 3, 4};
    longint cs;
    cyc = 0; n_checks = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; mode = 1'b0; continuous = 1'b0;
    vin = '0; comp_sel = 0; glitch = 1'b0; trace_en = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dac", dac_code, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    reset = 1'b1;

    // SAR on Vin=100 with trial-code trace
    trace.delete(); trace_en = 1'b1;
    do_conv(1'b1, 100, 0);
    trace_en = 1'b0;
    for (int i = 0; i < 8; i++)
      check("sar_trial", (i < trace.size()) ? trace[i] : -1, sar_exp[i]);

    // Ramp on Vin=3 with trace
    trace.delete(); trace_en = 1'b1;
    do_conv(1'b0, 3, 0);
    trace_en = 1'b0;
    for (int i = 0; i < 4; i++)
      check("ramp_code", (i < trace.size()) ? trace[i] : -1, ramp_exp[i]);

    // Ramp boundaries: comparator low at code 0, and tied high to full scale
    do_conv(1'b0, 0, 1);
    do_conv(1'b0, 0, 2);

    // Continuous SAR on Vin=200, three back-to-back results, then drop
    @(negedge clk);
    continuous = 1'b1;
    cs = cyc;
    vin = 8'd200; comp_sel = 0; mode = 1'b1; start = 1'b1;
    for (int i = 1; i <= 3; i++) sb.push_back('{200, cs + i * (W * STEP + 1), (i == 3)});
    @(negedge clk);
    start = 1'b0;
    while (cyc < cs + 2 * (W * STEP + 1) + 2) @(negedge clk);
    continuous = 1'b0;
    wait_drain(400);

    // Reset at cycle 20 of a SAR conversion aborts it
    @(negedge clk);
    cs = cyc;
    issue(1'b1, $urandom_range(1, 255), 0, 1'b1);
    while (cyc < cs + 20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_dac", dac_code, 0);
    check("abort_data", data, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", data_valid, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("abort_data_held", data, 0);
    // Start presented together with reset release is accepted on that edge
    reset = 1'b1;
    issue(1'b1, 77, 0, 1'b1);
    wait_drain(400);

    // Start pulses and comparator glitches outside the sampling windows
    @(negedge clk);
    cs = cyc;
    issue(1'b1, $urandom_range(0, 255), 0, 1'b1);
    for (int k = 0; k < W; k++) begin
      while (cyc < cs + 1 + k * STEP) @(negedge clk);
      glitch = 1'b1;
      start = k[0];
      mode = 1'b0;
      @(negedge clk);
      glitch = 1'b0;
      start = 1'b0;
    end
    wait_drain(400);

    // Randomized conversions
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      do_conv(1'($urandom), $urandom_range(0, 255), sel);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
